// File: rtl/spi_mem_burst.sv
// SPI mode-0 memory master: READ/WRITE command, ADDR_W-bit address, then a burst
// of len+1 data bytes, with CLK_DIV clk cycles per SCLK half-period.
module spi_mem_burst #(
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 4,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        wdata,
  output logic              wdata_ack,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  // Command, address and first data byte travel through one shifter, MSB first.
  localparam int SHIFT_W = ADDR_W + 16;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(ADDR_W);

  localparam logic [7:0]       CMD_READ  = 8'h03;
  localparam logic [7:0]       CMD_WRITE = 8'h02;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_GUARD = 3'd5
  } state_t;

  state_t             state_r,    state_s;
  logic [DIV_W-1:0]   div_cnt_r,  div_cnt_s;
  logic [BIT_W-1:0]   bit_cnt_r,  bit_cnt_s;
  logic [LEN_W-1:0]   byte_cnt_r, byte_cnt_s;
  logic [SHIFT_W-1:0] shift_r,    shift_s;
  logic [6:0]         rx_r,       rx_s;
  logic [7:0]         rdata_r,    rdata_s;
  logic               write_r,    write_s;
  logic               sclk_r,     sclk_s;
  logic               cs_r,       cs_s;
  logic               busy_r,     busy_s;
  logic               done_r,     done_s;
  logic               wack_r,     wack_s;
  logic               rvalid_r,   rvalid_s;

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    byte_cnt_s = byte_cnt_r;
    shift_s    = shift_r;
    rx_s       = rx_r;
    rdata_s    = rdata_r;
    write_s    = write_r;
    sclk_s     = sclk_r;
    cs_s       = cs_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    wack_s     = 1'b0;
    rvalid_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_CMD;
          write_s    = write;
          byte_cnt_s = len;
          bit_cnt_s  = BYTE_LAST;
          div_cnt_s  = '0;
          sclk_s     = 1'b0;
          cs_s       = 1'b0;
          busy_s     = 1'b1;
          shift_s    = {(write ? CMD_WRITE : CMD_READ), addr, (write ? wdata : 8'h00)};
          wack_s     = write;
        end else begin
          cs_s    = 1'b1;
          sclk_s  = 1'b0;
          busy_s  = 1'b0;
          shift_s = '0;
        end
      end
      ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA: begin
        if (div_cnt_r != DIV_LAST) begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end else if (!sclk_r) begin
          // End of low phase: sclk rises on this edge, so miso is sampled here.
          div_cnt_s = '0;
          sclk_s    = 1'b1;
          rx_s      = {rx_r[5:0], miso};
          if ((state_r == ST_RDATA) && (bit_cnt_r == '0)) begin
            rdata_s  = {rx_r, miso};
            rvalid_s = 1'b1;
          end else begin
            rvalid_s = 1'b0;
          end
        end else begin
          div_cnt_s = '0;
          sclk_s    = 1'b0;
          shift_s   = shift_r << 1;
          if (bit_cnt_r != '0) begin
            bit_cnt_s = bit_cnt_r - BIT_W'(1);
          end else begin
            case (state_r)
              ST_CMD: begin
                state_s   = ST_ADDR;
                bit_cnt_s = ADDR_LAST;
              end
              ST_ADDR: begin
                state_s   = write_r ? ST_WDATA : ST_RDATA;
                bit_cnt_s = BYTE_LAST;
              end
              ST_WDATA, ST_RDATA: begin
                if (byte_cnt_r == '0) begin
                  state_s = ST_GUARD;
                  cs_s    = 1'b1;
                end else begin
                  byte_cnt_s = byte_cnt_r - LEN_W'(1);
                  bit_cnt_s  = BYTE_LAST;
                  // Next write byte is taken as the previous one leaves the line.
                  if (state_r == ST_WDATA) begin
                    shift_s = {wdata, {(SHIFT_W - 8){1'b0}}};
                    wack_s  = 1'b1;
                  end else begin
                    wack_s  = 1'b0;
                  end
                end
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end
        end
      end
      ST_GUARD: begin
        if (div_cnt_r == DIV_LAST) begin
          state_s   = ST_IDLE;
          div_cnt_s = '0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_s    = 1'b1;
        sclk_s  = 1'b0;
        busy_s  = 1'b0;
        shift_s = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      byte_cnt_r <= '0;
      shift_r    <= '0;
      rx_r       <= '0;
      rdata_r    <= 8'h00;
      write_r    <= 1'b0;
      sclk_r     <= 1'b0;
      cs_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wack_r     <= 1'b0;
      rvalid_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      shift_r    <= shift_s;
      rx_r       <= rx_s;
      rdata_r    <= rdata_s;
      write_r    <= write_s;
      sclk_r     <= sclk_s;
      cs_r       <= cs_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      wack_r     <= wack_s;
      rvalid_r   <= rvalid_s;
    end
  end

  assign mosi        = shift_r[SHIFT_W-1];
  assign sclk        = sclk_r;
  assign cs          = cs_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign wdata_ack   = wack_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rvalid_r;

endmodule

// File: tb/tb_spi_mem_burst.sv
// Randomised bench for spi_mem_burst: two instances (16-bit/div 1 and 24-bit/div 3)
// checked against a bit-stream model of the SPI transaction.
module tb_spi_mem_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a, start_b, write, miso, sel;
  logic [23:0] addr;
  logic [3:0]  len;
  logic [7:0]  wdata;

  logic       wack_a, rvalid_a, busy_a, done_a, sclk_a, cs_a, mosi_a;
  logic       wack_b, rvalid_b, busy_b, done_b, sclk_b, cs_b, mosi_b;
  logic [7:0] rdata_a, rdata_b;

  logic       cur_wack, cur_rvalid, cur_busy, cur_done, cur_sclk, cur_cs, cur_mosi;
  logic [7:0] cur_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] bytes [16];
  logic       rx_bits [$];
  logic [7:0] rd_q [$];

  always #5 clk = ~clk;

  spi_mem_burst #(.ADDR_W(16), .LEN_W(4), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .write(write), .addr(addr[15:0]), .len(len),
    .wdata(wdata), .wdata_ack(wack_a), .rdata(rdata_a), .rdata_valid(rvalid_a),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso)
  );

  spi_mem_burst #(.ADDR_W(24), .LEN_W(4), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .write(write), .addr(addr), .len(len),
    .wdata(wdata), .wdata_ack(wack_b), .rdata(rdata_b), .rdata_valid(rvalid_b),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso)
  );

  assign cur_wack   = sel ? wack_b   : wack_a;
  assign cur_rvalid = sel ? rvalid_b : rvalid_a;
  assign cur_busy   = sel ? busy_b   : busy_a;
  assign cur_done   = sel ? done_b   : done_a;
  assign cur_sclk   = sel ? sclk_b   : sclk_a;
  assign cur_cs     = sel ? cs_b     : cs_a;
  assign cur_mosi   = sel ? mosi_b   : mosi_a;
  assign cur_rdata  = sel ? rdata_b  : rdata_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Device side: bit n of the miso stream (only data-phase bits of a read matter).
  function automatic logic dev_bit(input int n, input int aw, input bit wr);
    int idx;
    if (wr || n < 8 + aw) return 1'($urandom);
    idx = n - 8 - aw;
    if (idx >= 128) return 1'b0;
    return bytes[idx / 8][7 - (idx % 8)];
  endfunction

  function automatic logic [63:0] field(input int from, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], rx_bits[from + i]};
    return r;
  endfunction

  task automatic run_txn(input bit s, input bit wr, input logic [23:0] a, input logic [3:0] l,
                         input int abort_at, input bit intrude);
    int aw, cd, nbits, exp_done, cyc, rises, last_rise, first_rise, bad_period;
    int acks, valids, dones, done_cyc, cs_up;
    bit fin;
    logic prev_sclk;
    logic [23:0] exp_addr;
    aw       = s ? 24 : 16;
    cd       = s ? 3 : 1;
    nbits    = 8 + aw + 8 * (int'(l) + 1);
    exp_done = 2 * cd * nbits + cd;
    exp_addr = s ? a : {8'h00, a[15:0]};
    rx_bits.delete();
    rd_q.delete();
    rises = 0; last_rise = 0; first_rise = -1; bad_period = 0;
    acks = 0; valids = 0; dones = 0; done_cyc = -1; cs_up = -1; fin = 1'b0;
    sel   = s;
    write = wr;
    addr  = a;
    len   = l;
    wdata = wr ? bytes[0] : 8'($urandom);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("accept_cs", 64'(cur_cs), 64'd0);
    chk("accept_busy", 64'(cur_busy), 64'd1);
    chk("accept_sclk", 64'(cur_sclk), 64'd0);
    chk("accept_mosi", 64'(cur_mosi), 64'd0);
    miso = dev_bit(0, aw, wr);
    prev_sclk = 1'b0;
    cyc = 0;
    while (!fin && cyc <= exp_done + 40) begin
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_cs", 64'(cur_cs), 64'd1);
        chk("abort_sclk", 64'(cur_sclk), 64'd0);
        chk("abort_busy", 64'(cur_busy), 64'd0);
        chk("abort_mosi", 64'(cur_mosi), 64'd0);
        repeat (3) begin
          @(negedge clk);
          if (cur_done) dones++;
        end
        rst = 1'b0;
        chk("abort_no_done", 64'(dones), 64'd0);
        return;
      end
      if (intrude && cyc == 20) begin
        addr = a ^ 24'h00F0F0;
        len  = ~l;
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      if (intrude && cyc == 21) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (cur_sclk && !prev_sclk) begin
        rx_bits.push_back(cur_mosi);
        rises++;
        if (rises == 1) first_rise = cyc;
        else if (cyc - last_rise != 2 * cd) bad_period++;
        last_rise = cyc;
        miso = dev_bit(rises, aw, wr);
      end
      prev_sclk = cur_sclk;
      if (cur_cs && cs_up < 0) cs_up = cyc;
      if (cur_wack) begin
        acks++;
        wdata = (acks <= int'(l)) ? bytes[acks] : 8'($urandom);
      end
      if (cur_rvalid) begin
        valids++;
        rd_q.push_back(cur_rdata);
      end
      if (cur_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("txn_finished", 64'(fin), 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("first_rise", 64'(first_rise), 64'(cd));
    chk("half_period_errs", 64'(bad_period), 64'd0);
    chk("bit_count", 64'(rises), 64'(nbits));
    chk("cs_rise_cycle", 64'(cs_up), 64'(2 * cd * nbits));
    chk("idle_busy", 64'(cur_busy), 64'd0);
    chk("idle_cs", 64'(cur_cs), 64'd1);
    chk("idle_mosi", 64'(cur_mosi), 64'd0);
    chk("wdata_acks", 64'(acks), 64'(wr ? int'(l) + 1 : 0));
    chk("rdata_valids", 64'(valids), 64'(wr ? 0 : int'(l) + 1));
    if (rises == nbits) begin
      chk("cmd_byte", field(0, 8), wr ? 64'h02 : 64'h03);
      chk("addr_bits", field(8, aw), 64'(exp_addr));
      for (int k = 0; k <= int'(l); k++)
        chk("data_byte", field(8 + aw + 8 * k, 8), wr ? 64'(bytes[k]) : 64'h00);
    end
    for (int k = 0; k < rd_q.size() && k < 16; k++)
      chk("rdata", 64'(rd_q[k]), 64'(bytes[k]));
  endtask

  initial begin
    start_a = 1'b0; start_b = 1'b0; write = 1'b0; addr = '0; len = '0;
    wdata = 8'h00; miso = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_cs", 64'(cur_cs), 64'd1);
      chk("rst_sclk", 64'(cur_sclk), 64'd0);
      chk("rst_mosi", 64'(cur_mosi), 64'd0);
      chk("rst_busy", 64'(cur_busy), 64'd0);
      chk("rst_done", 64'(cur_done), 64'd0);
      chk("rst_wack", 64'(cur_wack), 64'd0);
      chk("rst_rvalid", 64'(cur_rvalid), 64'd0);
      chk("rst_rdata", 64'(cur_rdata), 64'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    bytes[0] = 8'hA5;
    run_txn(1'b0, 1'b0, 24'h001234, 4'd0, -1, 1'b0);

    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    run_txn(1'b0, 1'b1, 24'h0000FF, 4'd2, -1, 1'b0);

    for (int k = 0; k < 16; k++) bytes[k] = 8'($urandom);
    run_txn(1'b1, 1'b0, 24'hABCDEF, 4'd1, -1, 1'b0);

    for (int k = 0; k < 16; k++) bytes[k] = 8'($urandom);
    run_txn(1'b0, 1'b0, 24'h00BEEF, 4'd3, -1, 1'b1);

    run_txn(1'b0, 1'b0, 24'h004321, 4'd1, 25, 1'b0);
    for (int k = 0; k < 16; k++) bytes[k] = 8'($urandom);
    run_txn(1'b0, 1'b0, 24'h00CAFE, 4'd4, -1, 1'b0);

    for (int k = 0; k < 16; k++) bytes[k] = 8'(k);
    run_txn(1'b0, 1'b0, 24'($urandom), 4'd15, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 16; k++) bytes[k] = 8'($urandom);
      run_txn(i[0], 1'($urandom), 24'($urandom), 4'($urandom_range(0, 15)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_burst.md
# spi_mem_burst

Parametrised SPI memory master for the serial RAM/flash port; next generation of the single-byte SPI memory controller. Issues a READ (0x03) or WRITE (0x02) command, a configurable-width address, then a burst of 1..2^LEN_W data bytes, with a programmable SCLK divider. Sits between the CPU memory interface and the external SPI device. Byte-stream handshakes let the CPU stream data without restarting the transaction.

## Interface
- ADDR_W, 16: address bits shifted after the command; legal values 16 or 24.
- LEN_W, 4: width of `len`; burst is `len`+1 bytes, up to 2^LEN_W.
- CLK_DIV, 1: clk cycles per SCLK half-period, ≥1; 1 gives SCLK = clk/2.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only in IDLE
- write  in  1  1 = write burst, 0 = read burst; latched at accept
- addr  in  ADDR_W  start address; latched at accept
- len  in  LEN_W  byte count minus one; latched at accept
- wdata  in  8  write byte; byte 0 sampled at accept, later bytes sampled at `wdata_ack`
- wdata_ack  out  1  one-cycle pulse: `wdata` captured into shifter
- rdata  out  8  last received byte; held until the next byte completes
- rdata_valid  out  1  one-cycle pulse: `rdata` updated
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- sclk, cs, mosi  out  1 each  SPI mode 0, MSB first
- miso  in  1  SPI data in

## Operation
- States: IDLE → CMD (8 bits) → ADDR (ADDR_W bits) → WDATA or RDATA (8·(len+1) bits) → GUARD → IDLE.
- IDLE: cs=1, sclk=0, mosi=0, busy=0. On `start`: latch write/addr/len, load command byte, go to CMD. If write, also capture `wdata` as byte 0 and pulse `wdata_ack` in the same cycle.
- Bit timing: each bit is a low phase then a high phase, each CLK_DIV clk cycles. mosi changes only while sclk is low, at the start of the low phase. miso is sampled on the clk edge that drives sclk 0→1.
- CMD/ADDR: shift MSB first. The command value is fixed by `write`.
- WDATA: at the end of the high phase of bit 0 of byte k (k<len), capture `wdata` as byte k+1 and pulse `wdata_ack`. No back-pressure: the caller must present the next byte within 2·8·CLK_DIV−1 cycles after the previous ack.
- RDATA: mosi=0. After the 8th sample of each byte, `rdata` is updated and `rdata_valid` pulses on the next cycle.
- Byte counter decrements per byte. At 0 after the last bit, go to GUARD.
- GUARD: lasts CLK_DIV cycles with cs=1 and sclk=0. `done` pulses in the last GUARD cycle. busy falls with the return to IDLE.
- `start` while busy is ignored, and is not queued.
- Address arithmetic is the device's job; the block never increments `addr`.

## Timing
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, wdata_ack=0, rdata_valid=0, rdata=0x00. State is IDLE.
- Reset mid-transaction returns all outputs to reset values immediately. No `done` is issued.
- Accept edge T: cs=0 and busy=1 from T (registered outputs visible after T), and mosi = command bit 7.
- First sclk rise at T+CLK_DIV.
- Total transaction length from accept to done pulse: 2·CLK_DIV·(8+ADDR_W+8·(len+1)) + CLK_DIV cycles.
- Minimum start-to-start spacing equals that length + 1 cycle.
- len=0: exactly one data byte, and no mid-burst `wdata_ack`.
- len=2^LEN_W−1: full 2^LEN_W-byte burst with no counter wrap.
- When write=0 the `wdata` input is ignored.
- cs never glitches between bytes within a burst.

## Test plan
- Reset with defaults, then read len=0, addr=0x1234, device returns 0xA5: mosi shows 0x03,0x12,0x34, and 0 during data. `rdata`=0xA5 with one `rdata_valid` pulse; `done` arrives 2·(8+16+8)+1=65 cycles after accept.
- Write len=2, addr=0x00FF, bytes 0x11,0x22,0x33 supplied at each ack: mosi carries 0x02,0x00,0xFF,0x11,0x22,0x33. Exactly 3 `wdata_ack` pulses; cs stays low throughout.
- ADDR_W=24, CLK_DIV=3, read len=1, addr=0xABCDEF: 24 address bits are sent and sclk half-period is 3 cycles. Two `rdata_valid` pulses occur, and `done` arrives at 2·3·48+3=291 cycles.
- Assert `start` while busy with different addr: it is ignored, and the transaction completes unchanged.
- Assert rst during the ADDR phase: cs=1 and sclk=0 immediately, with no `done`. A new read afterwards completes correctly.
- Full burst len=15 read with incrementing miso bytes: 16 `rdata_valid` pulses carry 0x00..0x0F in order.
